// File: rtl/stream_max_if.sv
// Bundle of the input stream and result handshakes for stream_max.
// master drives beats and consumes results; slave is the block itself.
interface stream_max_if #(
  parameter int BITS     = 8,
  parameter int IDX_BITS = 4
);
  logic [BITS-1:0]     in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [BITS-1:0]     out_max;
  logic [IDX_BITS-1:0] out_idx;
  logic [IDX_BITS-1:0] out_count;
  logic                out_ovf;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_max, out_idx, out_count, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_max, out_idx, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/stream_max.sv
// Per-frame maximum finder: tracks the largest word, its earliest beat index,
// the beat count and an overflow flag, then holds the result until taken.
module stream_max #(
  parameter int BITS     = 8,
  parameter int IDX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  stream_max_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     max_q, max_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [IDX_BITS-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic in_ready;
  logic out_valid;
  logic beat_acc;
  logic res_take;
  logic cnt_full;

  // Handshake outputs come from the state register alone, never from inputs.
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  assign beat_acc = bus.in_valid && in_ready;
  assign res_take = out_valid && bus.out_ready;
  assign cnt_full = (cnt_q == {IDX_BITS{1'b1}});

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat_acc) state_d = bus.in_last ? HOLD : ACCUM;
      ACCUM:   if (beat_acc && bus.in_last) state_d = HOLD;
      HOLD:    if (res_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (beat_acc) begin
      if (state_q == IDLE) begin
        max_d = bus.in_data;
        idx_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (ovf_q || cnt_full) begin
        // Frame ran past the counter: keep consuming but freeze the result.
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        // Strict compare keeps the earliest index when values tie.
        if (bus.in_data > max_q) begin
          max_d = bus.in_data;
          idx_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears result fields too, so no stale result survives.
    if (!reset_n) begin
      state_q <= IDLE;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_max   = max_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_stream_max.sv
// Directed bench for stream_max (BITS=8, IDX_BITS=4): a cycle vector table
// followed by hand-written hold, overflow, reset and gap sequences.
module tb_stream_max;

  logic clk = 1'b0;
  logic reset_n;

  int n_cmp  = 0;
  int n_fail = 0;

  stream_max_if #(.BITS(8), .IDX_BITS(4)) bus ();

  stream_max #(.BITS(8), .IDX_BITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       ordy;
    logic       exp_valid;
    logic [7:0] exp_max;
    logic [3:0] exp_idx;
    logic [3:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [7:0] em,
                            input logic [3:0] ei, input logic [3:0] ec, input logic eo);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(!ev));
    if (ev) begin
      check({tag, "_max"}, 32'(bus.out_max), 32'(em));
      check({tag, "_idx"}, 32'(bus.out_idx), 32'(ei));
      check({tag, "_count"}, 32'(bus.out_count), 32'(ec));
      check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    end
  endtask

  task automatic expect_zero(input string tag);
    check({tag, "_max0"}, 32'(bus.out_max), 32'd0);
    check({tag, "_idx0"}, 32'(bus.out_idx), 32'd0);
    check({tag, "_count0"}, 32'(bus.out_count), 32'd0);
    check({tag, "_ovf0"}, 32'(bus.out_ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    expect_out("reset", 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);
    expect_zero("reset");

    // Frame 3,9,2,9,5(last) with out_ready high throughout, then 0xFF single beat.
    vecs[0] = '{1'b1, 8'd3,   1'b0, 1'b1, 1'b0, 8'd0,   4'd0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 8'd9,   1'b0, 1'b1, 1'b0, 8'd0,   4'd0, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 8'd2,   1'b0, 1'b1, 1'b0, 8'd0,   4'd0, 4'd0, 1'b0};
    vecs[3] = '{1'b1, 8'd9,   1'b0, 1'b1, 1'b0, 8'd0,   4'd0, 4'd0, 1'b0};
    vecs[4] = '{1'b1, 8'd5,   1'b1, 1'b1, 1'b1, 8'd9,   4'd1, 4'd4, 1'b0};
    vecs[5] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   4'd0, 4'd0, 1'b0};
    vecs[6] = '{1'b1, 8'hFF,  1'b1, 1'b0, 1'b1, 8'hFF,  4'd0, 4'd0, 1'b0};
    vecs[7] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   4'd0, 4'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = vecs[i].vld;
      bus.in_data   = vecs[i].data;
      bus.in_last   = vecs[i].last;
      bus.out_ready = vecs[i].ordy;
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_max,
                 vecs[i].exp_idx, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Result held for 5 cycles while the source keeps offering beats.
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("hold%0d", i), 1'b1, 8'd20, 4'd1, 4'd1, 1'b0);
    end
    take();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    expect_out("hold_taken", 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);
    beat(8'd7, 1'b1);
    expect_out("after_hold", 1'b1, 8'd7, 4'd0, 4'd0, 1'b0);
    take();

    // 18-beat frame 1..18 overflows the 4-bit counter.
    for (int v = 1; v <= 18; v++) beat(8'(v), (v == 18));
    expect_out("ovf", 1'b1, 8'd16, 4'd15, 4'd15, 1'b1);
    take();
    expect_out("ovf_taken", 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);
    beat(8'd3, 1'b1);
    expect_out("ovf_clear", 1'b1, 8'd3, 4'd0, 4'd0, 1'b0);
    take();

    // Reset mid-frame, with a beat offered on the reset edge.
    beat(8'd7, 1'b0);
    beat(8'd8, 1'b0);
    reset_n      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    bus.in_last  = 1'b1;
    tick();
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    expect_out("midrst", 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);
    expect_zero("midrst");
    beat(8'd4, 1'b0);
    expect_out("midrst_b0", 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);
    beat(8'd1, 1'b1);
    expect_out("midrst_res", 1'b1, 8'd4, 4'd0, 4'd1, 1'b0);
    take();

    // Gaps in in_valid mid-frame.
    beat(8'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("gap%0d", i), 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);
    end
    beat(8'd6, 1'b1);
    expect_out("gap_res", 1'b1, 8'd6, 4'd1, 4'd1, 1'b0);
    take();
    expect_out("gap_taken", 1'b0, 8'd0, 4'd0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
